// File: rtl/psi_pow4_issuer.sv
// psi_pow4_issuer: issues indexed psi operands into the fixed-latency psi^4
// pipeline with two-cycle spacing, collects the pipeline's non-stallable
// result stream in issue order, and presents {index, psi^4} on a ready/valid
// output. A DEPTH-entry slot ring tracks issued, returned and delivered work.
module psi_pow4_issuer #(
   parameter int DATA_W = 64,
   parameter int IDX_W  = 16,
   parameter int DEPTH  = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_W-1:0]       in_psi,
   input  logic [IDX_W-1:0]        in_idx,
   output logic                    start,
   output logic [DATA_W-1:0]       psi_o,
   input  logic                    res_vld,
   input  logic [DATA_W-1:0]       res_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [IDX_W-1:0]        out_idx,
   output logic [DATA_W-1:0]       out_data,
   output logic [$clog2(DEPTH):0]  inflight,
   output logic                    err
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);
   localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);

   // Slot ring storage (no reset: contents are only read behind valid pointers)
   logic [IDX_W-1:0]  slot_idx_q  [DEPTH];
   logic [DATA_W-1:0] slot_data_q [DEPTH];

   // Pointers carry a wrap bit so full and empty are distinguishable
   logic [PW-1:0]     iss_ptr_q, iss_ptr_d;
   logic [PW-1:0]     ret_ptr_q, ret_ptr_d;
   logic [PW-1:0]     out_ptr_q, out_ptr_d;
   logic [PW-1:0]     occ_d;

   logic              in_ready_q, in_ready_d;
   logic              start_q, start_d;
   logic [DATA_W-1:0] psi_q, psi_d;
   logic              out_valid_q, out_valid_d;
   logic [IDX_W-1:0]  out_idx_q, out_idx_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [PW-1:0]     inflight_q, inflight_d;
   logic              err_q, err_d;

   logic              accept_s;
   logic              pop_s;
   logic              ret_hit_s;
   logic              spur_s;
   logic              full_d;

   // Next-state: handshakes, pointer moves, and registered-output look-ahead
   always_comb begin
      accept_s  = in_valid & in_ready_q;
      pop_s     = out_valid_q & out_ready;
      ret_hit_s = res_vld & (ret_ptr_q != iss_ptr_q);
      spur_s    = res_vld & (ret_ptr_q == iss_ptr_q);

      iss_ptr_d = accept_s  ? (iss_ptr_q + PTR_ONE) : iss_ptr_q;
      ret_ptr_d = ret_hit_s ? (ret_ptr_q + PTR_ONE) : ret_ptr_q;
      out_ptr_d = pop_s     ? (out_ptr_q + PTR_ONE) : out_ptr_q;

      occ_d      = iss_ptr_d - out_ptr_d;
      full_d     = (occ_d == FULL_CNT);
      inflight_d = occ_d;

      // start is high the cycle after an accept; blocking in_ready while it is
      // high keeps psi_o stable across the pipeline's sample cycle.
      start_d    = accept_s;
      in_ready_d = ~full_d & ~accept_s;
      psi_d      = accept_s ? in_psi : psi_q;
      err_d      = err_q | spur_s;

      out_valid_d = (out_ptr_d != ret_ptr_d);
      out_idx_d   = slot_idx_q[out_ptr_d[AW-1:0]];
      // Bypass a result landing in the very slot being presented next cycle
      if (ret_hit_s && (ret_ptr_q[AW-1:0] == out_ptr_d[AW-1:0])) begin
         out_data_d = res_data;
      end else begin
         out_data_d = slot_data_q[out_ptr_d[AW-1:0]];
      end
   end

   // Control, pointer and output registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         iss_ptr_q   <= '0;
         ret_ptr_q   <= '0;
         out_ptr_q   <= '0;
         in_ready_q  <= 1'b0;
         start_q     <= 1'b0;
         psi_q       <= '0;
         out_valid_q <= 1'b0;
         out_idx_q   <= '0;
         out_data_q  <= '0;
         inflight_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         iss_ptr_q   <= iss_ptr_d;
         ret_ptr_q   <= ret_ptr_d;
         out_ptr_q   <= out_ptr_d;
         in_ready_q  <= in_ready_d;
         start_q     <= start_d;
         psi_q       <= psi_d;
         out_valid_q <= out_valid_d;
         out_idx_q   <= out_idx_d;
         out_data_q  <= out_data_d;
         inflight_q  <= inflight_d;
         err_q       <= err_d;
      end
   end

   // Slot writes: index at accept, result data at in-order return
   always_ff @(posedge clk) begin
      if (accept_s) begin
         slot_idx_q[iss_ptr_q[AW-1:0]] <= in_idx;
      end
      if (ret_hit_s) begin
         slot_data_q[ret_ptr_q[AW-1:0]] <= res_data;
      end
   end

   assign in_ready  = in_ready_q;
   assign start     = start_q;
   assign psi_o     = psi_q;
   assign out_valid = out_valid_q;
   assign out_idx   = out_idx_q;
   assign out_data  = out_data_q;
   assign inflight  = inflight_q;
   assign err       = err_q;

endmodule

// File: tb/tb_psi_pow4_issuer.sv
// Bench for psi_pow4_issuer: behavioural pipeline model (real-valued psi^4
// with fixed latency) plus a queue scoreboard checked every cycle, a constant
// table of single operations, and directed multi-cycle sequences.
module tb_psi_pow4_issuer;

   localparam int DATA_W = 64;
   localparam int IDX_W  = 16;
   localparam int DEPTH  = 32;
   localparam int LAT    = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_psi;
   logic [IDX_W-1:0]  in_idx;
   logic              start;
   logic [DATA_W-1:0] psi_o;
   logic              res_vld;
   logic [DATA_W-1:0] res_data;
   logic              out_valid;
   logic              out_ready;
   logic [IDX_W-1:0]  out_idx;
   logic [DATA_W-1:0] out_data;
   logic [5:0]        inflight;
   logic              err;

   psi_pow4_issuer #(.DATA_W(DATA_W), .IDX_W(IDX_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_psi(in_psi), .in_idx(in_idx),
      .start(start), .psi_o(psi_o),
      .res_vld(res_vld), .res_data(res_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_idx(out_idx), .out_data(out_data),
      .inflight(inflight), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct { logic [IDX_W-1:0] idx; logic [DATA_W-1:0] psi; } op_t;
   typedef struct { int due; logic [DATA_W-1:0] data; } pr_t;
   typedef struct { logic [IDX_W-1:0] idx; logic [DATA_W-1:0] psi; logic [DATA_W-1:0] want; } vec_t;

   op_t  exp_q[$];
   pr_t  pipe_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   acc_cnt, ret_cnt, pop_cnt, cyc, last_acc_cyc;
   bit   prev_acc, alive, m_err, cap_pend, pipe_en;
   bit   last_acc, last_pop;
   logic [DATA_W-1:0] last_psi;
   logic [IDX_W-1:0]  pop_idx;
   logic [DATA_W-1:0] pop_data;

   function automatic logic [63:0] pow4(input logic [63:0] b);
      real r;
      r = $bitstoreal(b);
      return $realtobits(r * r * r * r);
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
      n_vec++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, want, cyc);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      pipe_q.delete();
      acc_cnt = 0; ret_cnt = 0; pop_cnt = 0;
      prev_acc = 1'b0; alive = 1'b0; m_err = 1'b0; cap_pend = 1'b0;
      last_psi = '0;
   endtask

   // One clock: check outputs at negedge, update model, then drive pipeline
   task automatic cycle();
      bit acc, pop;
      @(negedge clk);
      last_acc = 1'b0;
      last_pop = 1'b0;
      if (!rst) begin
         chk("in_ready", 64'(in_ready), 64'(alive && !prev_acc && ((acc_cnt - pop_cnt) < DEPTH)));
         chk("start", 64'(start), 64'(prev_acc));
         chk("psi_o", psi_o, last_psi);
         chk("inflight", 64'(inflight), 64'(acc_cnt - pop_cnt));
         chk("err", 64'(err), 64'(m_err));
         chk("out_valid", 64'(out_valid), 64'(ret_cnt > pop_cnt));
         if (ret_cnt > pop_cnt && exp_q.size() > 0) begin
            chk("out_idx", 64'(out_idx), 64'(exp_q[0].idx));
            chk("out_data", out_data, pow4(exp_q[0].psi));
         end
         if (cap_pend && pipe_en) pipe_q.push_back('{cyc + LAT, pow4(psi_o)});
         cap_pend = start;
         acc = in_valid && in_ready;
         pop = out_valid && out_ready;
         if (res_vld) begin
            if (acc_cnt == ret_cnt) m_err = 1'b1;
            else ret_cnt++;
         end
         if (pop) begin
            pop_idx = out_idx; pop_data = out_data; last_pop = 1'b1;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            pop_cnt++;
         end
         if (acc) begin
            exp_q.push_back('{in_idx, in_psi});
            acc_cnt++;
            last_psi = in_psi;
            last_acc = 1'b1;
            last_acc_cyc = cyc;
         end
         prev_acc = acc;
         alive = 1'b1;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (pipe_en) begin
         if (pipe_q.size() > 0 && pipe_q[0].due <= cyc) begin
            res_vld = 1'b1; res_data = pipe_q[0].data; void'(pipe_q.pop_front());
         end else begin
            res_vld = 1'b0; res_data = '0;
         end
      end
   endtask

   task automatic send(input logic [IDX_W-1:0] idx, input logic [DATA_W-1:0] psi);
      bit got;
      got = 1'b0;
      in_valid = 1'b1; in_idx = idx; in_psi = psi;
      for (int k = 0; k < 300; k++) begin
         cycle();
         if (last_acc) begin got = 1'b1; break; end
      end
      chk("accept_timeout", 64'(got), 64'd1);
   endtask

   task automatic drain();
      bit done;
      done = 1'b0;
      in_valid = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < 1000; k++) begin
         if (acc_cnt == pop_cnt && pipe_q.size() == 0 && !cap_pend) begin done = 1'b1; break; end
         cycle();
      end
      chk("drain_timeout", 64'(done), 64'd1);
   endtask

   function automatic logic [63:0] rnd_psi();
      logic [63:0] v;
      v = $realtobits(real'($urandom_range(1, 40)) / 8.0);
      v[63] = 1'($urandom_range(0, 1));
      return v;
   endfunction

   vec_t tbl[5];
   op_t  ops[3];
   logic [DATA_W-1:0] d_psi;
   int   prev_cyc;
   bit   got;

   initial begin
      tbl[0] = '{16'd5,      64'h4000000000000000, 64'h4030000000000000};
      tbl[1] = '{16'd7,      64'h3FF0000000000000, 64'h3FF0000000000000};
      tbl[2] = '{16'hFFFF,   64'hC000000000000000, 64'h4030000000000000};
      tbl[3] = '{16'd0,      64'h3FE0000000000000, 64'h3FB0000000000000};
      tbl[4] = '{16'd3,      64'h4008000000000000, 64'h4054400000000000};

      rst = 1'b1; in_valid = 1'b0; in_psi = '0; in_idx = '0;
      res_vld = 1'b0; res_data = '0; out_ready = 1'b0;
      cyc = 0; pipe_en = 1'b1;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_inflight", 64'(inflight), 64'd0);
      chk("rst_psi_o", psi_o, 64'd0);
      rst = 1'b0;

      // Table of single operations with constant expected results
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         send(tbl[i].idx, tbl[i].psi);
         in_valid = 1'b0;
         if (i == 0) chk("single_inflight", 64'(inflight), 64'd1);
         got = 1'b0;
         for (int k = 0; k < 50; k++) begin
            cycle();
            if (last_pop) begin got = 1'b1; break; end
         end
         chk("tbl_pop_timeout", 64'(got), 64'd1);
         chk("tbl_idx", 64'(pop_idx), 64'(tbl[i].idx));
         chk("tbl_data", pop_data, tbl[i].want);
         cycle();
         chk("tbl_inflight_zero", 64'(inflight), 64'd0);
      end

      // Back-to-back stream: accepts exactly two cycles apart
      prev_cyc = 0;
      for (int i = 0; i < 10; i++) begin
         send(16'(i), rnd_psi());
         if (i > 0) chk("b2b_spacing", 64'(last_acc_cyc - prev_cyc), 64'd2);
         prev_cyc = last_acc_cyc;
      end
      drain();
      chk("b2b_err", 64'(err), 64'd0);

      // Backpressure to full, then resume across pointer wrap
      out_ready = 1'b0;
      for (int i = 0; i < 32; i++) send(16'(100 + i), rnd_psi());
      in_valid = 1'b1; in_idx = 16'd132; in_psi = rnd_psi();
      repeat (8) cycle();
      chk("full_inflight", 64'(inflight), 64'd32);
      chk("full_in_ready", 64'(in_ready), 64'd0);
      out_ready = 1'b1;
      for (int i = 32; i < 40; i++) send(16'(100 + i), rnd_psi());
      drain();

      // Accept, result and pop in the same cycle with three in flight
      pipe_en = 1'b0; out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         ops[i] = '{16'(200 + i), rnd_psi()};
         send(ops[i].idx, ops[i].psi);
      end
      in_valid = 1'b0;
      repeat (2) cycle();
      res_vld = 1'b1; res_data = pow4(ops[0].psi);
      cycle();
      res_vld = 1'b0;
      cycle();
      chk("simul_pre_inflight", 64'(inflight), 64'd3);
      chk("simul_pre_ready", 64'(in_ready), 64'd1);
      d_psi = rnd_psi();
      in_valid = 1'b1; in_idx = 16'd203; in_psi = d_psi;
      out_ready = 1'b1; res_vld = 1'b1; res_data = pow4(ops[1].psi);
      cycle();
      in_valid = 1'b0; out_ready = 1'b0; res_vld = 1'b0;
      chk("simul_acc", 64'(last_acc), 64'd1);
      chk("simul_pop", 64'(last_pop), 64'd1);
      chk("simul_inflight", 64'(inflight), 64'd3);
      cycle();
      res_vld = 1'b1; res_data = pow4(ops[2].psi);
      cycle();
      res_vld = 1'b1; res_data = pow4(d_psi);
      cycle();
      res_vld = 1'b0;
      cycle();
      pipe_en = 1'b1;
      drain();

      // Randomized traffic against the model
      for (int k = 0; k < 800; k++) begin
         in_valid  = ($urandom_range(0, 2) != 0);
         in_idx    = 16'($urandom);
         in_psi    = rnd_psi();
         out_ready = ($urandom_range(0, 9) < 7);
         cycle();
      end
      drain();

      // Spurious result with nothing outstanding
      pipe_en = 1'b0;
      res_vld = 1'b1; res_data = 64'h0123456789ABCDEF;
      cycle();
      res_vld = 1'b0;
      cycle();
      chk("spur_err", 64'(err), 64'd1);
      chk("spur_out_valid", 64'(out_valid), 64'd0);
      repeat (5) cycle();
      chk("spur_err_sticky", 64'(err), 64'd1);

      // Asynchronous reset with four in flight
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(16'(300 + i), rnd_psi());
      in_valid = 1'b0;
      cycle();
      chk("prerst_inflight", 64'(inflight), 64'd4);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_in_ready", 64'(in_ready), 64'd0);
      chk("arst_start", 64'(start), 64'd0);
      chk("arst_psi_o", psi_o, 64'd0);
      chk("arst_out_valid", 64'(out_valid), 64'd0);
      chk("arst_out_idx", 64'(out_idx), 64'd0);
      chk("arst_out_data", out_data, 64'd0);
      chk("arst_inflight", 64'(inflight), 64'd0);
      chk("arst_err", 64'(err), 64'd0);
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      pipe_en = 1'b1;
      cycle();
      chk("post_rst_in_ready", 64'(in_ready), 64'd1);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) send(16'(400 + i), rnd_psi());
      drain();
      chk("post_rst_err", 64'(err), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
